// File: rtl/jtframe_db15_pkg.sv
// Shared definitions for the DB15 joystick serial transmitter.
//   DefJoyW      - default bits per joystick word
//   DefChainLen  - default serial chain length (two joysticks)
//   db15_state_e - transmitter state encoding
package jtframe_db15_pkg;

    localparam int unsigned DefJoyW     = 16;
    localparam int unsigned DefChainLen = 2 * DefJoyW;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StDone
    } db15_state_e;

endpackage

// File: rtl/jtframe_db15_sync.sv
// Multi-stage synchronizer with rising-edge detector for one asynchronous wire.
//   clk_i  - system clock
//   rst_i  - asynchronous active-high reset; all stages reset to 1 (idle wire level)
//   din_i  - asynchronous input
//   s_o    - synchronized level
//   rise_o - one-cycle pulse on a 0->1 transition of s_o
module jtframe_db15_sync #(
    parameter int unsigned SYNC = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic s_o,
    output logic rise_o
);

    logic [SYNC-1:0] stage_q, stage_d;
    logic            prev_q, prev_d;

    always_comb begin
        stage_d = {stage_q[SYNC-2:0], din_i};
        prev_d  = stage_q[SYNC-1];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q <= '1;
            prev_q  <= 1'b1;
        end else begin
            stage_q <= stage_d;
            prev_q  <= prev_d;
        end
    end

    assign s_o    = stage_q[SYNC-1];
    assign rise_o = stage_q[SYNC-1] & ~prev_q;

endmodule

// File: rtl/jtframe_db15_tx.sv
// DB15 joystick serial transmitter. Presents both joysticks as an active-low
// serial chain, joystick1[0] first, clocked by an external reader.
//   clk_sys    - system clock
//   rst        - asynchronous active-high reset
//   joystick1  - player 1 buttons, active-high
//   joystick2  - player 2 buttons, active-high
//   JOY_CLK    - reader shift clock (asynchronous)
//   JOY_LOAD   - reader parallel-load strobe, active-low (asynchronous)
//   JOY_DATA   - registered serial data, active-low on the wire
//   frame_done - one-cycle pulse after the last chain bit is shifted out
//   overrun    - sticky; set by shift clocks after the chain is exhausted
module jtframe_db15_tx
    import jtframe_db15_pkg::*;
#(
    parameter int unsigned JOYW = DefJoyW,
    parameter int unsigned SYNC = 2
) (
    input  logic            clk_sys,
    input  logic            rst,
    input  logic [JOYW-1:0] joystick1,
    input  logic [JOYW-1:0] joystick2,
    input  logic            JOY_CLK,
    input  logic            JOY_LOAD,
    output logic            JOY_DATA,
    output logic            frame_done,
    output logic            overrun
);

    localparam int unsigned ChainLen = 2 * JOYW;
    localparam int unsigned CntW     = $clog2(ChainLen) + 1;

    logic ld_s, ld_rise;
    logic ck_s, ck_rise;

    jtframe_db15_sync #(.SYNC(SYNC)) u_sync_ld (
        .clk_i  (clk_sys),
        .rst_i  (rst),
        .din_i  (JOY_LOAD),
        .s_o    (ld_s),
        .rise_o (ld_rise)
    );

    jtframe_db15_sync #(.SYNC(SYNC)) u_sync_ck (
        .clk_i  (clk_sys),
        .rst_i  (rst),
        .din_i  (JOY_CLK),
        .s_o    (ck_s),
        .rise_o (ck_rise)
    );

    // Only the load level and the clock edge drive the FSM.
    logic unused_sync;
    assign unused_sync = ^{ck_s, ld_rise};

    db15_state_e         state_q, state_d;
    logic [ChainLen-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                data_q, data_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        done_d    = 1'b0;
        overrun_d = overrun_q;
        // Load has priority over everything, including a coincident clock edge.
        if (!ld_s) begin
            state_d   = StLoad;
            shreg_d   = ~{joystick2, joystick1};
            cnt_d     = '0;
            data_d    = ~joystick1[0];
            overrun_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: data_d = 1'b1;
                StLoad: begin
                    state_d = StShift;
                    cnt_d   = '0;
                    data_d  = shreg_q[0];
                end
                StShift: begin
                    if (ck_rise) begin
                        shreg_d = {1'b1, shreg_q[ChainLen-1:1]};
                        if (cnt_q < CntW'(ChainLen)) begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                        if (cnt_q == CntW'(ChainLen - 1)) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                            data_d  = 1'b1;
                        end else begin
                            // New bit appears in the same cycle as the shift.
                            data_d = shreg_q[1];
                        end
                    end
                end
                StDone: begin
                    data_d = 1'b1;
                    if (ck_rise) begin
                        overrun_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            shreg_q   <= '1;
            cnt_q     <= '0;
            data_q    <= 1'b1;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign JOY_DATA   = data_q;
    assign frame_done = done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_jtframe_db15_tx.sv
module tb_jtframe_db15_tx;

    localparam int JW = 16;
    localparam int CL = 2 * JW;

    logic          clk_sys = 1'b0;
    logic          rst;
    logic [JW-1:0] joystick1, joystick2;
    logic          JOY_CLK, JOY_LOAD;
    logic          JOY_DATA, frame_done, overrun;

    jtframe_db15_tx #(.JOYW(JW), .SYNC(2)) u_dut (
        .clk_sys    (clk_sys),
        .rst        (rst),
        .joystick1  (joystick1),
        .joystick2  (joystick2),
        .JOY_CLK    (JOY_CLK),
        .JOY_LOAD   (JOY_LOAD),
        .JOY_DATA   (JOY_DATA),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk_sys = ~clk_sys;

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard: one entry per JOY_CLK rising edge; -1 means "do not check".
    int exp_q[$];

    // Reference model of the chain as seen by the reader.
    logic [JW-1:0] ref_j1, ref_j2;
    int            ref_idx    = 0;
    bit            ref_active = 0;
    bit            ref_over   = 0;
    int            exp_done   = 0;
    int            done_cnt   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ref_bit(input int i);
        if (!ref_active || i >= CL) return 1;
        if (i < JW) return int'(!ref_j1[i]);
        return int'(!ref_j2[i - JW]);
    endfunction

    // Monitor: the reader captures JOY_DATA at its clock rising edge.
    initial begin
        int e;
        forever begin
            @(posedge JOY_CLK);
            #1;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_clk: got pulse expected none at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                if (e >= 0) check("joy_data", {31'd0, JOY_DATA}, e);
            end
        end
    end

    always @(negedge clk_sys) if (frame_done === 1'b1) done_cnt++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic clk_pulse();
        exp_q.push_back(ref_bit(ref_idx));
        if (ref_active && ref_idx == CL - 1) exp_done++;
        if (ref_active && ref_idx >= CL) ref_over = 1;
        ref_idx++;
        @(negedge clk_sys);
        JOY_CLK = 1'b1;
        repeat (8) @(negedge clk_sys);
        JOY_CLK = 1'b0;
        repeat (8) @(negedge clk_sys);
    endtask

    task automatic load_frame(input logic [JW-1:0] j1, input logic [JW-1:0] j2,
                              input int low_cycles, input bit with_clk);
        @(negedge clk_sys);
        joystick1 = j1;
        joystick2 = j2;
        if (with_clk) begin
            exp_q.push_back(-1);
            JOY_CLK = 1'b1;
        end
        JOY_LOAD = 1'b0;
        repeat (low_cycles) @(negedge clk_sys);
        check("overrun_clr", {31'd0, overrun}, 0);
        JOY_CLK = 1'b0;
        repeat (4) @(negedge clk_sys);
        JOY_LOAD = 1'b1;
        repeat (6) @(negedge clk_sys);
        ref_j1 = j1; ref_j2 = j2;
        ref_idx = 0; ref_active = 1; ref_over = 0;
    endtask

    task automatic full_frame(input string tag);
        repeat (CL) clk_pulse();
        check({tag, "_done"}, done_cnt, exp_done);
        check({tag, "_over"}, {31'd0, overrun}, {31'd0, ref_over});
        check({tag, "_idle_data"}, {31'd0, JOY_DATA}, 1);
    endtask

    initial begin
        logic [JW-1:0] a, b;
        rst = 1'b1; JOY_CLK = 1'b0; JOY_LOAD = 1'b1;
        joystick1 = '0; joystick2 = '0;
        repeat (3) @(negedge clk_sys);
        check("rst_data", {31'd0, JOY_DATA}, 1);
        check("rst_done", {31'd0, frame_done}, 0);
        check("rst_over", {31'd0, overrun}, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk_sys);

        // Fixed pattern: 0 + fifteen 1s, fifteen 1s + 0, then overrun.
        load_frame(16'h0001, 16'h8000, 10, 0);
        full_frame("fixed");
        repeat (3) clk_pulse();
        check("overrun_set", {31'd0, overrun}, {31'd0, ref_over});
        check("overrun_set_data", {31'd0, JOY_DATA}, 1);

        // Abort after 10 shifts, then complete the restarted frame.
        load_frame(JW'($urandom), JW'($urandom), 10, 0);
        repeat (10) clk_pulse();
        a = JW'($urandom); b = JW'($urandom);
        load_frame(a, b, 10, 0);
        check("abort_done", done_cnt, exp_done);
        check("abort_cnt", {26'd0, u_dut.cnt_q}, 0);
        full_frame("restart");

        // Joystick changes mid-shift do not affect the frame.
        load_frame(16'h0000, JW'($urandom), 10, 0);
        repeat (5) clk_pulse();
        joystick1 = 16'hFFFF;
        full_frame("frozen_partial");

        // Reset mid-frame at bit 20 (bit 20 forced to drive JOY_DATA low).
        a = JW'($urandom); b = JW'($urandom) | 16'h0010;
        load_frame(a, b, 10, 0);
        repeat (20) clk_pulse();
        check("pre_rst_data", {31'd0, JOY_DATA}, 0);
        #2 rst = 1'b1;
        #1 check("async_rst_data", {31'd0, JOY_DATA}, 1);
        check("async_rst_over", {31'd0, overrun}, 0);
        repeat (3) @(negedge clk_sys);
        rst = 1'b0;
        ref_active = 0; ref_idx = 0;
        exp_done = done_cnt;
        repeat (5) clk_pulse();
        check("post_rst_done", done_cnt, exp_done);

        // Clock edge coincident with load falling is ignored.
        load_frame(JW'($urandom), JW'($urandom), 10, 0);
        repeat (7) clk_pulse();
        load_frame(JW'($urandom), JW'($urandom), 10, 1);
        full_frame("coincide");

        // Random frames with varying load pulse widths.
        for (int k = 0; k < 4; k++) begin
            load_frame(JW'($urandom), JW'($urandom), 10 + int'($urandom_range(0, 20)), 0);
            full_frame("random");
        end

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
